// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch front end with a two-entry fetch queue.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   imem_addr         byte address to instruction memory (the PC register)
//   imem_rd           instruction word for imem_addr, same cycle
//   redirect_valid    flush queue and load PC from redirect_pc
//   redirect_pc       redirect target byte address (low two bits ignored)
//   halt              suppress new fetches; queue keeps draining
//   inst_valid        queue head holds an instruction
//   inst_data/inst_pc registered head entry
//   inst_ready        consumer takes the head entry this cycle
//   fetch_count       pushes since reset, wraps at 16 bits
//
// state  | meaning
// -------+------------------------------------------------
// RUN    | fetch allowed; pushes when the queue has room
// HALTED | halt asserted; no pushes, PC retained
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] QD = 2'(QDEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] head_pc_q, head_data_q;
  logic [31:0] tail_pc_q, tail_data_q;
  logic [1:0]  count_q;
  logic [15:0] fcount_q;
  logic        pop, push;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      RUN:     if (halt)  state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase
    pop = (count_q != 2'd0) && inst_ready;
    // Next state is used so that dropping halt fetches in that same cycle.
    if (!redirect_valid && (state_d == RUN))
      push = (count_q < QD) || pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      fcount_q    <= 16'd0;
      head_pc_q   <= 32'd0;
      head_data_q <= 32'd0;
      tail_pc_q   <= 32'd0;
      tail_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        count_q <= 2'd0;
        pc_q    <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (push) begin
          pc_q     <= pc_q + 32'd4;
          fcount_q <= fcount_q + 16'd1;
        end
        case ({push, pop})
          2'b10: begin
            if (count_q == 2'd0) begin
              head_pc_q   <= pc_q;
              head_data_q <= imem_rd;
            end else begin
              tail_pc_q   <= pc_q;
              tail_data_q <= imem_rd;
            end
            count_q <= count_q + 2'd1;
          end
          2'b01: begin
            head_pc_q   <= tail_pc_q;
            head_data_q <= tail_data_q;
            count_q     <= count_q - 2'd1;
          end
          2'b11: begin
            // Count stays; the new word lands wherever the popped slot frees up.
            if (count_q == 2'd1) begin
              head_pc_q   <= pc_q;
              head_data_q <= imem_rd;
            end else begin
              head_pc_q   <= tail_pc_q;
              head_data_q <= tail_data_q;
              tail_pc_q   <= pc_q;
              tail_data_q <= imem_rd;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr   = pc_q;
  assign inst_valid  = (count_q != 2'd0);
  assign inst_data   = head_data_q;
  assign inst_pc     = head_pc_q;
  assign fetch_count = fcount_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter QDEPTH, fixed value 2, number of entries in the fetch queue.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  32  byte address driven to the instruction memory A port; SHALL equal the PC register.
REQ-006 imem_rd  input  32  instruction word from the memory RD port, combinational in imem_addr within the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 halt  input  1  when high, new fetches are suppressed; the queue still drains.
REQ-010 inst_valid  output  1  queue head holds a valid instruction.
REQ-011 inst_data  output  32  instruction word at the queue head.
REQ-012 inst_pc  output  32  byte address of inst_data.
REQ-013 inst_ready  input  1  decode accepts the head entry this cycle.
REQ-014 fetch_count  output  16  number of instructions pushed since reset.

Function
REQ-015 Pop SHALL occur in a cycle when inst_valid and inst_ready are both 1; the head entry then leaves the queue at the next edge.
REQ-016 Push-enable SHALL be true when rst=0, redirect_valid=0, halt=0, and (count<2 or pop); on push, {PC, imem_rd} enters the tail and PC advances by 4.
REQ-017 PC SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
REQ-018 Redirect SHALL flush all queue entries, load PC with {redirect_pc[31:2],2'b00}, perform no push or pop accounting, and hold inst_valid at 0 for the following cycle.
REQ-019 Priority SHALL be rst > redirect_valid > halt > normal fetch.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; this is legal at count=2.
REQ-021 inst_valid SHALL be (count!=0); inst_data and inst_pc SHALL be registered queue outputs with no combinational path from imem_rd.
REQ-022 Latency: an instruction fetched in cycle N SHALL be visible at the head in cycle N+1 if the queue was empty.
REQ-023 Order SHALL be preserved: entries leave in the order pushed, and inst_pc of consecutive entries without an intervening redirect SHALL differ by 4.
REQ-024 When inst_valid=1 and inst_ready=0, inst_data and inst_pc SHALL remain stable.
REQ-025 fetch_count SHALL increment by 1 per push, wrap at 16'hFFFF, and be unaffected by redirect.
REQ-026 Internal states: RUN (push-enable may assert) and HALTED (halt=1); halt deassertion SHALL resume fetch at the retained PC in the same cycle.

Reset
REQ-027 On rst=1 at an edge: PC=RESET_PC, count=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_count=0.
REQ-028 Reset asserted mid-operation SHALL discard queue contents and any simultaneous redirect.
REQ-029 During rst=1, imem_addr SHALL equal RESET_PC from the cycle after the first reset edge.

Verification
REQ-030 Reset, then inst_ready=1 steady, memory returning word=addr -> inst_pc/inst_data sequence 0,4,8,12... one per cycle from the second cycle after reset release.
REQ-031 inst_ready=0 for 5 cycles -> count saturates at 2, imem_addr stalls at 8, head stays at pc 0; then inst_ready=1 -> pcs 0,4,8 emerge in order, no loss or duplicate.
REQ-032 Redirect to 32'h0000_0043 while queue is full -> next cycle inst_valid=0, imem_addr=32'h40; next head inst_pc=32'h40.
REQ-033 Redirect and rst in the same cycle -> PC=RESET_PC, queue empty.
REQ-034 Redirect to 32'hFFFF_FFF8, free-run 3 fetches -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 halt=1 for 4 cycles with inst_ready=1 -> queue drains to empty, fetch_count frozen, PC unchanged; halt=0 -> fetch resumes at the retained PC.
